// File: rtl/gpio_ctrl.sv
// PicoBlaze port-mapped GPIO controller: direction/data registers, input sync, edge interrupts.
// Optional input debounce is compiled in with GPIO_CTRL_DEBOUNCE_EN.
module gpio_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter logic [7:0]  BASE_ADDR = 8'h00
`ifdef GPIO_CTRL_DEBOUNCE_EN
   , parameter int unsigned DEBOUNCE_CYCLES = 16
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       port_id,
   input  logic             write_strobe,
   input  logic             read_strobe,
   input  logic [7:0]       out_port,
   output logic [7:0]       in_port,
   output logic             interrupt,
   input  logic             interrupt_ack,
   output logic [WIDTH-1:0] gpio_oen,
   output logic [WIDTH-1:0] gpio_data_out,
   input  logic [WIDTH-1:0] gpio_data_in
);

   localparam logic [2:0] OFS_DOUT  = 3'd0;
   localparam logic [2:0] OFS_DIR   = 3'd1;
   localparam logic [2:0] OFS_DIN   = 3'd2;
   localparam logic [2:0] OFS_IMASK = 3'd3;
   localparam logic [2:0] OFS_ISTAT = 3'd4;
   localparam logic [2:0] OFS_EDGE  = 3'd5;
   localparam logic [7:0] NUM_REGS  = 8'd6;

   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] dir_prev_q;
   logic [WIDTH-1:0] imask_q, imask_d;
   logic [WIDTH-1:0] istat_q, istat_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] din_val;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] wdata;
   logic [7:0]       offset;
   logic             hit;
   logic             wr_dout, wr_dir, wr_imask, wr_istat, wr_edge;
   logic             irq_q, irq_d;
   logic             unmask_set;
   logic [7:0]       in_port_q, in_port_d;
   logic             unused_inputs;

   // Address decode relative to BASE_ADDR; wraps modulo 256
   assign offset   = port_id - BASE_ADDR;
   assign hit      = (offset < NUM_REGS);
   assign wdata    = out_port[WIDTH-1:0];
   assign wr_dout  = write_strobe & hit & (offset[2:0] == OFS_DOUT);
   assign wr_dir   = write_strobe & hit & (offset[2:0] == OFS_DIR);
   assign wr_imask = write_strobe & hit & (offset[2:0] == OFS_IMASK);
   assign wr_istat = write_strobe & hit & (offset[2:0] == OFS_ISTAT);
   assign wr_edge  = write_strobe & hit & (offset[2:0] == OFS_EDGE);

   assign unused_inputs = read_strobe ^ (^out_port);

   assign dout_d  = wr_dout  ? wdata : dout_q;
   assign dir_d   = wr_dir   ? wdata : dir_q;
   assign imask_d = wr_imask ? wdata : imask_q;
   assign edge_d  = wr_edge  ? wdata : edge_q;

   // Output-mode bits loop back DOUT so a floating pin never reaches the flops
   assign sync1_d = (dir_q & dout_q) | (~dir_q & gpio_data_in);

`ifdef GPIO_CTRL_DEBOUNCE_EN
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] deb_q, deb_d;

   // Debounced value follows sync only after DEBOUNCE_CYCLES consecutive mismatches
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_q <= '0;
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign din_val = deb_q;
`else
   assign din_val = sync2_q;
`endif

   // Edges only count when the bit has been an input for two cycles
   assign evt = ~dir_q & ~dir_prev_q &
                ((edge_q & ~prev_q & din_val) | (~edge_q & prev_q & ~din_val));

   assign istat_d    = (istat_q & ~(wr_istat ? wdata : '0)) | evt;
   assign unmask_set = wr_imask & (|(wdata & ~imask_q & istat_q));
   assign irq_d      = (|(evt & imask_q)) | unmask_set | (irq_q & ~interrupt_ack);

   // Read data registered every cycle from the current port_id
   always_comb begin
      in_port_d = '0;
      if (hit) begin
         case (offset[2:0])
            OFS_DOUT:  in_port_d = 8'(dout_q);
            OFS_DIR:   in_port_d = 8'(dir_q);
            OFS_DIN:   in_port_d = 8'(din_val);
            OFS_IMASK: in_port_d = 8'(imask_q);
            OFS_ISTAT: in_port_d = 8'(istat_q);
            OFS_EDGE:  in_port_d = 8'(edge_q);
            default:   in_port_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q     <= '0;
         dir_q      <= '0;
         dir_prev_q <= '0;
         imask_q    <= '0;
         istat_q    <= '0;
         edge_q     <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         irq_q      <= 1'b0;
         in_port_q  <= '0;
      end else begin
         dout_q     <= dout_d;
         dir_q      <= dir_d;
         dir_prev_q <= dir_q;
         imask_q    <= imask_d;
         istat_q    <= istat_d;
         edge_q     <= edge_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync1_q;
         prev_q     <= din_val;
         irq_q      <= irq_d;
         in_port_q  <= in_port_d;
      end
   end

   assign gpio_oen      = dir_q;
   assign gpio_data_out = dout_q;
   assign interrupt     = irq_q;
   assign in_port       = in_port_q;

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- PicoBlaze port-mapped controller for a bank of WIDTH gpio_bit instances.
- Holds the direction and output-data registers that drive each bit's gpio_oen and gpio_data_out.
- Synchronises each bit's gpio_data_in and detects edges on input-mode bits.
- Raises a PicoBlaze interrupt on a selected edge, held until interrupt_ack.

Parameters:
- WIDTH, 8: number of GPIO bits, legal 1..8; register bits above WIDTH read 0 and ignore writes.
- BASE_ADDR, 8'h00: port_id of register offset 0; the block decodes BASE_ADDR..BASE_ADDR+5.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- port_id  input  8  PicoBlaze port address.
- write_strobe  input  1  one-cycle write qualifier.
- read_strobe  input  1  one-cycle read qualifier (informational; reads have no side effects).
- out_port  input  8  PicoBlaze write data.
- in_port  output  8  registered read data.
- interrupt  output  1  PicoBlaze interrupt request.
- interrupt_ack  input  1  PicoBlaze interrupt acknowledge.
- gpio_oen  output  WIDTH  per-bit output enable to gpio_bit.
- gpio_data_out  output  WIDTH  per-bit drive value to gpio_bit.
- gpio_data_in  input  WIDTH  per-bit sampled pin from gpio_bit; Z/X while that bit's oen=1.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 DOUT: R/W, reset 0.
  - 1 DIR: R/W, 1 = output, reset 0 (all inputs).
  - 2 DIN: read-only.
  - 3 IMASK: R/W, reset 0.
  - 4 ISTAT: read; write-1-to-clear; reset 0.
  - 5 EDGE: R/W, 1 = rising, 0 = falling; reset 0.
- Writes: on write_strobe with port_id matching an offset, the register updates at that clock edge. Writes to DIN or unmapped addresses are ignored.
- Outputs: gpio_oen = DIR; gpio_data_out = DOUT; both are direct register outputs.
- Input synchroniser: two-flop per bit, reset 0.
  - Stage-1 input is gpio_data_in when DIR=0, else DOUT. This keeps Z/X out of the flops.
  - A third flop holds the previous synchronised value for edge detection, reset 0.
- DIN read value = synchronised stage-2 value. Pin-to-DIN latency is 2 clocks.
- Edge event (bit i): requires DIR[i]=0, both in the current cycle and in the previous cycle (so a direction change cannot produce a false edge).
  - EDGE[i]=1: event when prev=0 and sync=1.
  - EDGE[i]=0: event when prev=1 and sync=0.
- ISTAT[i] sets on an event regardless of IMASK (pollable).
  - ISTAT[i] clears when ISTAT is written with out_port[i]=1.
  - Event and clear on the same cycle: set wins.
- Interrupt:
  - interrupt flop (reset 0) sets in the cycle after any bit i has an event with IMASK[i]=1.
  - It clears on interrupt_ack. Ack and a new masked event on the same cycle: remains 1.
  - It is not re-asserted by already-pending ISTAT bits. A write to IMASK that unmasks an already-set ISTAT bit sets interrupt on the next cycle.
- Read path: in_port is registered every clock from port_id decode, so data is valid 1 cycle after port_id. This meets the PicoBlaze 2-cycle input timing. Unmapped offsets read 8'h00. Reset value 8'h00.
- Reset mid-operation: all registers and flops clear asynchronously; pins float (DIR=0). The first edge after reset release requires a real transition from 0 or 1 after sync fill; a pin held high gives a spurious rising event at most once. This is mitigated by ISTAT being cleared by software after reset.

Optional Feature:
- Macro GPIO_CTRL_DEBOUNCE_EN.
- Defined:
  - Adds parameter DEBOUNCE_CYCLES (default 16) and a per-bit counter after the synchroniser.
  - The debounced value updates only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive clocks. The counter resets to 0 on any match.
  - DIN and edge detection use the debounced value. Pin-to-DIN latency becomes 2 + DEBOUNCE_CYCLES.
- Undefined: no counters; behaviour exactly as above.

Test Plan:
- Reset, then read offsets 0-5 → all 8'h00; gpio_oen=0, interrupt=0.
- Write DIR=8'hF0, DOUT=8'hA5 → gpio_oen=F0, gpio_data_out=A5; DIN reads upper nibble A (loop-back), lower nibble = driven pins after 2 clocks.
- DIR=0, EDGE=8'h01, IMASK=8'h01, pin0 0→1 → ISTAT=01 and interrupt=1 by clock 4; pin0 1→0 → no new event.
- interrupt_ack asserted the same cycle as a new masked event on bit1 (EDGE[1]=0, falling) → interrupt stays 1; write ISTAT=8'h03 → ISTAT=00.
- Bit2 unmasked, edge occurs → ISTAT=04, interrupt=0; then write IMASK=04 → interrupt=1 next cycle.
- With GPIO_CTRL_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle glitch on pin3 → no DIN change, no ISTAT; a 20-cycle pulse → DIN[3]=1 at clock 18 and ISTAT[3] set.
